// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared instruction memory constants and loader state encoding
package imem_loader_pkg;

  localparam int IMEM_DEPTH     = 8192;
  localparam int IMEM_AW        = 13;
  localparam int BYTES_PER_WORD = 4;
  localparam int IMEM_DW        = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - assembles MSB-first bytes into words, one-cycle word pulse
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               shift,
  input  logic [7:0]         in_data,
  output logic               last_byte,
  output logic               word_valid,
  output logic [IMEM_DW-1:0] word
);

  logic [1:0]         byte_idx;
  logic [IMEM_DW-1:0] sr;

  // The byte now being shifted completes a word
  assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));

  // The shift register still holds the full word in the pulse cycle, even if
  // the next word's first byte is accepted that same cycle.
  assign word = sr;

  // Shift bytes in and flag the cycle after the fourth byte of each word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx   <= '0;
      sr         <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      byte_idx   <= '0;
      sr         <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= shift && last_byte;
      if (shift) begin
        sr       <= {sr[IMEM_DW-9:0], in_data};
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a header-prefixed byte stream into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW,
  parameter int DW    = IMEM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [DW-1:0] imem_wdata,
  output logic [AW:0]   program_size,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err
);

  state_t      state, state_next;
  logic [15:0] cnt;
  logic [AW:0] widx;
  logic [AW:0] widx_inc;
  logic [15:0] hdr_cnt;
  logic        accept;
  logic        data_shift;
  logic        last_byte;
  logic        word_accept;
  logic        word_last;
  logic        hdr_done;

  assign accept      = in_valid && in_ready;
  assign hdr_cnt     = {cnt[15:8], in_data};
  assign hdr_done    = accept && (state == ST_HDR1);
  assign data_shift  = accept && (state == ST_DATA);
  assign word_accept = data_shift && last_byte;
  assign widx_inc    = widx + (AW+1)'(1);
  assign word_last   = (widx_inc == cnt[AW:0]);

  imem_loader_byte_packer u_byte_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (hdr_done),
    .shift      (data_shift),
    .in_data    (in_data),
    .last_byte  (last_byte),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and status decode; the final word's write pulse coincides with DONE
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    cpu_hold   = 1'b0;
    load_done  = 1'b0;
    load_err   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        load_done = (state == ST_DONE);
        load_err  = (state == ST_ERR);
        if (start) state_next = ST_HDR0;
      end
      ST_HDR0: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (accept) state_next = ST_HDR1;
      end
      ST_HDR1: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (accept) begin
          if (hdr_cnt == 16'd0)             state_next = ST_DONE;
          else if (hdr_cnt > 16'(DEPTH))    state_next = ST_ERR;
          else                              state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (word_accept && word_last) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Header count, word address and committed program size
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      widx         <= '0;
      imem_addr    <= '0;
      program_size <= '0;
    end else begin
      if (accept && (state == ST_HDR0)) cnt[15:8] <= in_data;
      if (hdr_done) begin
        cnt[7:0] <= in_data;
        widx     <= '0;
        if (hdr_cnt == 16'd0) program_size <= '0;
      end
      if (word_accept) begin
        imem_addr <= widx[AW-1:0];
        widx      <= widx_inc;
        if (word_last) program_size <= cnt[AW:0];
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [12:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [13:0] program_size;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int          n_vec = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  int          last_addr = -1;
  logic [44:0] exp_q[$];
  logic [31:0] img[8192];

  imem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .program_size (program_size),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (imem_we) begin
      logic [44:0] e;
      wr_cnt++;
      last_addr = int'(imem_addr);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e[44:32]));
        chk("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic outputs_zero(input string tag);
    chk({tag, "_we"},    32'(imem_we), 0);
    chk({tag, "_ready"}, 32'(in_ready), 0);
    chk({tag, "_addr"},  32'(imem_addr), 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_psize"}, 32'(program_size), 0);
    chk({tag, "_hold"},  32'(cpu_hold), 0);
    chk({tag, "_done"},  32'(load_done), 0);
    chk({tag, "_err"},   32'(load_err), 0);
  endtask

  task automatic start_load();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("hold_after_start", 32'(cpu_hold), 1);
    chk("ready_in_hdr0", 32'(in_ready), 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd, input bit pulse);
    int  guard;
    bit  first;
    guard = 0;
    first = 1'b1;
    forever begin
      @(negedge clk);
      start = pulse && first;
      first = 1'b0;
      if (rnd && ($urandom_range(0, 1) == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        if (in_ready) break;
      end
      guard++;
      if (guard > 64) begin
        chk("byte_timeout", 0, 1);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic load_image(input int hdr, input int nsend, input bit rnd, input int start_at);
    logic [15:0] h;
    logic [7:0]  b;
    int          bi;
    h  = hdr[15:0];
    bi = 0;
    send_byte(h[15:8], rnd, 1'b0);
    send_byte(h[7:0], rnd, 1'b0);
    for (int w = 0; w < nsend; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[w][31-8*k -: 8];
        if (k == 3) exp_q.push_back({13'(w), img[w]});
        send_byte(b, rnd, bi == start_at);
        bi++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(load_done || load_err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(load_done || load_err)) chk({tag, "_timeout"}, 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_end(input string tag, input int psize, input bit done, input int writes);
    chk({tag, "_psize"}, 32'(program_size), 32'(psize));
    chk({tag, "_done"},  32'(load_done), 32'(done));
    chk({tag, "_err"},   32'(load_err), 32'(!done));
    chk({tag, "_hold"},  32'(cpu_hold), 0);
    chk({tag, "_writes"}, 32'(writes), 32'(wr_cnt));
    chk({tag, "_qempty"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int w0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    img[0]   = 32'h1234_5678;
    img[1]   = 32'h9ABC_DEF0;
    img[2]   = 32'h0BAD_F00D;
    #23;
    outputs_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Two-word image, stream never stalls
    w0 = wr_cnt;
    start_load();
    load_image(2, 2, 1'b0, -1);
    wait_done("basic");
    check_end("basic", 2, 1'b1, w0 + 2);

    // Same image with random valid gaps
    w0 = wr_cnt;
    start_load();
    load_image(2, 2, 1'b1, -1);
    wait_done("stall");
    check_end("stall", 2, 1'b1, w0 + 2);

    // Oversized header: error, nothing consumed afterwards
    w0 = wr_cnt;
    start_load();
    load_image(8193, 0, 1'b0, -1);
    wait_done("err");
    @(negedge clk); in_valid = 1'b1;
    #1 chk("err_ready", 32'(in_ready), 0);
    @(negedge clk); in_valid = 1'b0;
    check_end("err", 2, 1'b0, w0);

    // Empty image
    w0 = wr_cnt;
    start_load();
    load_image(0, 0, 1'b0, -1);
    wait_done("empty");
    check_end("empty", 0, 1'b1, w0);

    // start during DATA is ignored
    w0 = wr_cnt;
    start_load();
    load_image(3, 3, 1'b0, 6);
    wait_done("midstart");
    check_end("midstart", 3, 1'b1, w0 + 3);

    // Reset after five data bytes, then reload
    start_load();
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] b;
      b = (k < 4) ? img[0][31-8*k -: 8] : img[1][31:24];
      if (k == 3) exp_q.push_back({13'd0, img[0]});
      send_byte(b, 1'b0, 1'b0);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    #1 outputs_zero("midrst");
    chk("midrst_qempty", 32'(exp_q.size()), 0);
    @(negedge clk); rst_n = 1'b1;
    w0 = wr_cnt;
    start_load();
    load_image(2, 2, 1'b0, -1);
    wait_done("reload");
    check_end("reload", 2, 1'b1, w0 + 2);

    // Full-depth image
    for (int i = 0; i < 8192; i++) img[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    w0 = wr_cnt;
    start_load();
    load_image(8192, 8192, 1'b0, -1);
    wait_done("full");
    check_end("full", 8192, 1'b1, w0 + 8192);
    chk("full_last_addr", 32'(last_addr), 32'd8191);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction fetch path: loads a program image into the instruction memory word array (8192 x 32) at run time, replacing file-based preload.
- Consumes a byte stream over valid/ready: 2-byte header (word count), then words MSB-first. Produces one-cycle word writes to the memory write port.
- Reports program size in words for end-of-program detection, and holds the CPU while loading.

Parameters:
- DEPTH, 8192, instruction memory depth in words
- AW, 13, word address width (log2 DEPTH)
- DW, 32, word width; fixed at 4 bytes per word

Ports:
- clk  in  1  master clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load; honoured only in IDLE, DONE or ERR
- in_valid  in  1  byte stream valid
- in_data  in  8  byte stream data
- in_ready  out  1  loader accepts a byte this cycle when in_valid && in_ready
- imem_we  out  1  memory write enable, one-cycle pulse per word
- imem_addr  out  AW  word address for the write
- imem_wdata  out  DW  assembled word
- program_size  out  AW+1  word count of the last successful load; 0 until one completes
- cpu_hold  out  1  high from start acceptance until DONE or ERR
- load_done  out  1  level; high in DONE
- load_err  out  1  level; high in ERR

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; program_size=0.
  - Internal byte counter, word counter and shift register cleared.
  - Reset mid-load abandons the load; words already written stay in memory, but program_size stays 0.
- States: IDLE, HDR0, HDR1, DATA, DONE, ERR.
- IDLE/DONE/ERR:
  - in_ready=0.
  - start moves to HDR0 next cycle; cpu_hold=1 and load_done/load_err=0 from that cycle.
- HDR0: in_ready=1; on accept, latch cnt[15:8]; go to HDR1.
- HDR1: in_ready=1; on accept, latch cnt[7:0]. Then:
  - cnt==0: go to DONE; program_size=0.
  - cnt>DEPTH: go to ERR.
  - otherwise: go to DATA; word index=0; byte index=0.
- DATA:
  - in_ready=1 every cycle, no backpressure.
  - Each accepted byte shifts in: word = {word[23:0], in_data}. First byte becomes bits [31:24].
  - On the accept of byte index 3, the next cycle has imem_we=1, imem_addr=word index, imem_wdata=assembled word (registered; one-cycle latency).
  - Word index increments on that accept. Byte index wraps 3->0.
  - A new byte may be accepted in the same cycle imem_we is high, so back-to-back words are sustained at 4 cycles/word.
  - After the write of word cnt-1: go to DONE in the same cycle imem_we pulses.
  - On entering DONE: program_size=cnt, cpu_hold=0.
- Cycles with in_valid=0 leave all counters unchanged. The stream may stall indefinitely.
- start while in HDR0/HDR1/DATA: ignored.
- ERR: cpu_hold=0; program_size retains its previous value; bytes are not consumed.
- imem_addr never exceeds DEPTH-1: guaranteed by the header check. cnt==DEPTH is legal (last address 8191).
- Exactly one memory write per word; no writes occur outside DATA.

Decomposition:
- Shared package: state encoding (IDLE..ERR), IMEM_DEPTH=8192, IMEM_AW=13, BYTES_PER_WORD=4. The instruction memory read side uses the same depth constant.
- Sub-module byte_packer: shift register plus 2-bit byte counter, emitting word_valid/word. The FSM and address counter stay in imem_loader.

Test Plan:
- Reset then start; stream 00 02 | 12 34 56 78 | 9A BC DE F0 with in_valid held high.
  - Writes: addr0=0x12345678, then addr1=0x9ABCDEF0, each with imem_we high for 1 cycle.
  - program_size=2, load_done=1, cpu_hold=0.
  - Exactly 2 write pulses.
- Same image with in_valid toggled randomly (50%) -> identical writes and final state; no extra writes or dropped bytes.
- Header 00 00 -> DONE directly; no imem_we; program_size=0.
- Header 20 01 (8193) -> ERR; load_err=1; in_ready=0; no writes; program_size unchanged from the prior load (e.g. 2).
- Header 20 00 (8192), followed by 32768 bytes -> last write at addr 8191; program_size=8192.
- rst_n pulled low after 5 data bytes -> all outputs 0 immediately (asynchronous), state IDLE; a following start reloads from header correctly.
- start pulsed during DATA -> ignored; load completes normally.
